// File: rtl/mux4x1_rr_arbiter.sv
// Four-channel round-robin arbiter with a registered 4:1 data mux select.
// Each tenure is capped at MAX_HOLD cycles and followed by a one-cycle release.
module mux4x1_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       valid,
  output logic       y
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [1:0] sel, sel_n;
  logic [7:0] hold, hold_n;
  logic [3:0] gnt_n;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      sel   <= 2'd0;
      hold  <= 8'd0;
      gnt   <= 4'b0000;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      hold  <= hold_n;
      gnt   <= gnt_n;
    end
  end

  // First requester at or after ptr, wrapping modulo 4
  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    hold_n  = hold;
    gnt_n   = gnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << win;
          sel_n   = win;
          hold_n  = 8'd1;
        end
      end
      GRANT: begin
        if (!req[sel] || hold >= HOLD_MAX) begin
          state_n = RELEASE;
          gnt_n   = 4'b0000;
          ptr_n   = sel + 2'd1;
        end else begin
          hold_n = hold + 8'd1;
        end
      end
      RELEASE: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
      end
    endcase
  end

  always_comb begin
    valid = |gnt;
    s1    = sel[1];
    s0    = sel[0];
    y     = 1'b0;
    case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
    y = y & valid;
  end

endmodule
